// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, types and trellis helpers for the K=4 Viterbi decoder
package viterbi_pkg;

  localparam int NSTATES = 8;
  localparam int PM_W    = 8;
  localparam int BM_W    = 2;

  localparam logic [3:0] G0 = 4'b1101;
  localparam logic [3:0] G1 = 4'b1111;

  typedef logic [2:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  function automatic state_t pred0(state_t ns);
    return {ns[1:0], 1'b0};
  endfunction

  function automatic state_t pred1(state_t ns);
    return {ns[1:0], 1'b1};
  endfunction

  // Codeword {c0,c1} emitted when input bit b is shifted into encoder state p.
  function automatic logic [1:0] enc_cw(state_t p, logic b);
    logic [3:0] r;
    r = {b, p};
    return {^(r & G0), ^(r & G1)};
  endfunction

endpackage

// File: rtl/acs_scheduler_acs.sv
// rtl/acs_scheduler_acs.sv - combinational add-compare-select for one trellis state
module acs_scheduler_acs
  import viterbi_pkg::*;
#(
  parameter int PM_W = viterbi_pkg::PM_W,
  parameter int BM_W = viterbi_pkg::BM_W
) (
  input  logic [PM_W-1:0] path_0_pmc,
  input  logic            path_0_valid,
  input  logic [BM_W-1:0] path_0_bmc,
  input  logic [PM_W-1:0] path_1_pmc,
  input  logic            path_1_valid,
  input  logic [BM_W-1:0] path_1_bmc,
  output logic            selection,
  output logic            valid_o,
  output logic [PM_W-1:0] path_cost
);

  logic [PM_W-1:0] cost_0;
  logic [PM_W-1:0] cost_1;

  // Ties favour path 0; an invalid path can never win.
  always_comb begin
    cost_0    = path_0_pmc + {{(PM_W-BM_W){1'b0}}, path_0_bmc};
    cost_1    = path_1_pmc + {{(PM_W-BM_W){1'b0}}, path_1_bmc};
    selection = path_1_valid && (!path_0_valid || (cost_1 < cost_0));
    valid_o   = path_0_valid || path_1_valid;
    path_cost = selection ? cost_1 : cost_0;
  end

endmodule

// File: rtl/acs_scheduler.sv
// rtl/acs_scheduler.sv - time-multiplexes one ACS over 8 trellis states with double-buffered path metrics
module acs_scheduler
  import viterbi_pkg::*;
#(
  parameter int PM_W    = viterbi_pkg::PM_W,
  parameter int BM_W    = viterbi_pkg::BM_W,
  parameter int NORM_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic [4*BM_W-1:0] in_bm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_surv,
  output logic [7:0]        out_pm_valid,
  output logic [2:0]        out_best_state,
  output logic [PM_W-1:0]   out_best_cost,
  output logic              busy
);

  sched_state_e state_q, state_d;
  state_t       ns_q, ns_d;
  logic [4*BM_W-1:0] bm_q, bm_d;
  logic bank_q, bank_d;

  logic [NSTATES-1:0][PM_W-1:0] pm0_q, pm0_d, pm1_q, pm1_d;
  logic [NSTATES-1:0]           v0_q, v0_d, v1_q, v1_d;
  logic [NSTATES-1:0]           surv_q, surv_d;

  logic            min_found_q, min_found_d;
  logic [PM_W-1:0] min_cost_q, min_cost_d;
  state_t          min_state_q, min_state_d;

  logic [7:0]      out_surv_q, out_surv_d;
  logic [7:0]      out_pm_valid_q, out_pm_valid_d;
  state_t          out_best_state_q, out_best_state_d;
  logic [PM_W-1:0] out_best_cost_q, out_best_cost_d;

  logic [NSTATES-1:0][PM_W-1:0] rd_pm, wr_pm;
  logic [NSTATES-1:0]           rd_v, wr_v;

  state_t          p0, p1;
  logic [1:0]      cw0, cw1;
  logic [BM_W-1:0] bmc0, bmc1;
  logic            acs_sel, acs_valid;
  logic [PM_W-1:0] acs_cost;

  function automatic logic [BM_W-1:0] pick_bm(input logic [4*BM_W-1:0] bms, input logic [1:0] cw);
    return bms[BM_W*int'(cw) +: BM_W];
  endfunction

  // bank_q selects which bank is read; the other one collects this symbol's results.
  always_comb begin
    rd_pm = bank_q ? pm1_q : pm0_q;
    rd_v  = bank_q ? v1_q  : v0_q;
    p0    = pred0(ns_q);
    p1    = pred1(ns_q);
    cw0   = enc_cw(p0, ns_q[2]);
    cw1   = enc_cw(p1, ns_q[2]);
    bmc0  = pick_bm(bm_q, cw0);
    bmc1  = pick_bm(bm_q, cw1);
  end

  acs_scheduler_acs #(
    .PM_W (PM_W),
    .BM_W (BM_W)
  ) u_acs (
    .path_0_pmc   (rd_pm[p0]),
    .path_0_valid (rd_v[p0]),
    .path_0_bmc   (bmc0),
    .path_1_pmc   (rd_pm[p1]),
    .path_1_valid (rd_v[p1]),
    .path_1_bmc   (bmc1),
    .selection    (acs_sel),
    .valid_o      (acs_valid),
    .path_cost    (acs_cost)
  );

  logic [NSTATES-1:0][PM_W-1:0] rd_pm_n, wr_pm_n;
  logic [NSTATES-1:0]           rd_v_n, wr_v_n;
  logic [NSTATES-1:0]           surv_nx;
  logic                         found_cur, cand_better, min_found_nx;
  logic [PM_W-1:0]              min_cost_nx;
  state_t                       min_state_nx;

  always_comb begin
    state_d          = state_q;
    ns_d             = ns_q;
    bm_d             = bm_q;
    bank_d           = bank_q;
    surv_d           = surv_q;
    min_found_d      = min_found_q;
    min_cost_d       = min_cost_q;
    min_state_d      = min_state_q;
    out_surv_d       = out_surv_q;
    out_pm_valid_d   = out_pm_valid_q;
    out_best_state_d = out_best_state_q;
    out_best_cost_d  = out_best_cost_q;
    rd_pm_n          = rd_pm;
    rd_v_n           = rd_v;
    wr_pm            = bank_q ? pm0_q : pm1_q;
    wr_v             = bank_q ? v0_q  : v1_q;
    wr_pm_n          = wr_pm;
    wr_v_n           = wr_v;

    // Running minimum restarts at ns = 0 and includes the current cycle's result.
    found_cur    = min_found_q && (ns_q != 3'd0);
    cand_better  = acs_valid && (!found_cur || (acs_cost < min_cost_q));
    min_found_nx = found_cur || acs_valid;
    min_cost_nx  = cand_better ? acs_cost : min_cost_q;
    min_state_nx = cand_better ? ns_q : min_state_q;
    surv_nx      = surv_q;
    surv_nx[ns_q] = acs_sel;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bm_d    = in_bm;
          ns_d    = 3'd0;
          state_d = RUN;
          if (in_first) begin
            rd_pm_n = '0;
            rd_v_n  = 8'h01;
          end
        end
      end
      RUN: begin
        wr_pm_n[ns_q] = acs_cost;
        wr_v_n[ns_q]  = acs_valid;
        surv_d        = surv_nx;
        min_found_d   = min_found_nx;
        min_cost_d    = min_cost_nx;
        min_state_d   = min_state_nx;
        ns_d          = ns_q + 3'd1;
        if (ns_q == 3'd7) begin
          for (int i = 0; i < NSTATES; i++) begin
            if (!wr_v_n[i]) begin
              wr_pm_n[i] = '0;
            end else if (NORM_EN != 0) begin
              wr_pm_n[i] = wr_pm_n[i] - min_cost_nx;
            end
          end
          state_d          = DONE;
          bank_d           = ~bank_q;
          out_surv_d       = surv_nx;
          out_pm_valid_d   = wr_v_n;
          out_best_state_d = min_found_nx ? min_state_nx : 3'd0;
          out_best_cost_d  = min_found_nx ? min_cost_nx : '0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pm0_d = bank_q ? wr_pm_n : rd_pm_n;
    pm1_d = bank_q ? rd_pm_n : wr_pm_n;
    v0_d  = bank_q ? wr_v_n  : rd_v_n;
    v1_d  = bank_q ? rd_v_n  : wr_v_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      ns_q             <= 3'd0;
      bm_q             <= '0;
      bank_q           <= 1'b0;
      pm0_q            <= '0;
      pm1_q            <= '0;
      v0_q             <= 8'h01;
      v1_q             <= 8'h01;
      surv_q           <= '0;
      min_found_q      <= 1'b0;
      min_cost_q       <= '0;
      min_state_q      <= 3'd0;
      out_surv_q       <= '0;
      out_pm_valid_q   <= 8'h01;
      out_best_state_q <= 3'd0;
      out_best_cost_q  <= '0;
    end else begin
      state_q          <= state_d;
      ns_q             <= ns_d;
      bm_q             <= bm_d;
      bank_q           <= bank_d;
      pm0_q            <= pm0_d;
      pm1_q            <= pm1_d;
      v0_q             <= v0_d;
      v1_q             <= v1_d;
      surv_q           <= surv_d;
      min_found_q      <= min_found_d;
      min_cost_q       <= min_cost_d;
      min_state_q      <= min_state_d;
      out_surv_q       <= out_surv_d;
      out_pm_valid_q   <= out_pm_valid_d;
      out_best_state_q <= out_best_state_d;
      out_best_cost_q  <= out_best_cost_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign busy           = (state_q == RUN) || (state_q == DONE);
  assign out_surv       = out_surv_q;
  assign out_pm_valid   = out_pm_valid_q;
  assign out_best_state = out_best_state_q;
  assign out_best_cost  = out_best_cost_q;

endmodule

// File: tb/tb_acs_scheduler.sv
// tb/tb_acs_scheduler.sv - directed and model-checked bench for acs_scheduler
module tb_acs_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_first, out_ready;
  logic [7:0] in_bm;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_surv, out_pm_valid, out_best_cost;
  logic [2:0] out_best_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  acs_scheduler #(.PM_W(8), .BM_W(2), .NORM_EN(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_first       (in_first),
    .in_bm          (in_bm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_surv       (out_surv),
    .out_pm_valid   (out_pm_valid),
    .out_best_state (out_best_state),
    .out_best_cost  (out_best_cost),
    .busy           (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic first, input logic [7:0] bm);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_first = first;
    in_bm    = bm;
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [7:0] surv, input logic [7:0] pmv,
                              input logic [2:0] bs, input logic [7:0] bc);
    check_eq({tag, "_surv"}, 32'(out_surv), 32'(surv));
    check_eq({tag, "_pm_valid"}, 32'(out_pm_valid), 32'(pmv));
    check_eq({tag, "_best_state"}, 32'(out_best_state), 32'(bs));
    check_eq({tag, "_best_cost"}, 32'(out_best_cost), 32'(bc));
  endtask

  // Forward-propagating reference trellis with unbounded integer metrics.
  int m_pm[8];
  bit m_v[8];

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pm[i] = 0;
      m_v[i]  = 1'b0;
    end
    m_v[0] = 1'b1;
  endtask

  task automatic model_step(input logic first, input logic [7:0] bm, output logic [7:0] e_surv,
                            output logic [7:0] e_valid, output logic [2:0] e_bs, output logic [7:0] e_bc);
    int  best[8];
    bit  set[8];
    bit  from1[8];
    int  mn, ms, ns, cost, r3, r2, r1, r0, c0, c1;
    bit  any;
    if (first) model_reset();
    for (int i = 0; i < 8; i++) begin
      set[i] = 1'b0; best[i] = 0; from1[i] = 1'b0;
    end
    for (int p = 0; p < 8; p++) begin
      if (m_v[p]) begin
        for (int b = 0; b < 2; b++) begin
          ns = b * 4 + p / 2;
          r3 = b; r2 = (p >> 2) & 1; r1 = (p >> 1) & 1; r0 = p & 1;
          c0 = r3 ^ r2 ^ r0;
          c1 = r3 ^ r2 ^ r1 ^ r0;
          cost = m_pm[p] + ((bm >> (2 * (c0 * 2 + c1))) & 3);
          if (!set[ns] || cost < best[ns]) begin
            set[ns] = 1'b1; best[ns] = cost; from1[ns] = bit'(p & 1);
          end
        end
      end
    end
    any = 1'b0; mn = 0; ms = 0;
    for (int i = 0; i < 8; i++) begin
      if (set[i] && (!any || best[i] < mn)) begin
        any = 1'b1; mn = best[i]; ms = i;
      end
    end
    for (int i = 0; i < 8; i++) begin
      e_surv[i]  = from1[i];
      e_valid[i] = set[i];
      m_v[i]     = set[i];
      m_pm[i]    = set[i] ? best[i] - mn : 0;
    end
    e_bs = 3'(ms);
    e_bc = 8'(mn);
  endtask

  initial begin
    int lat;
    logic [7:0] e_surv, e_valid, e_bc;
    logic [2:0] e_bs;
    logic [7:0][7:0] rd;
    logic [7:0] rdv;
    logic [7:0] bm;
    logic first;
    int mn, mx;
    logic [7:0] t4_pmv [4];

    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_bm = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_result("rst", 8'h00, 8'h01, 3'd0, 8'd0);

    // First symbol from frame start: only states 0 and 4 become reachable.
    send(1'b1, 8'h94);
    check_eq("t2_busy_run", 32'(busy), 32'd1);
    wait_done(lat);
    check_eq("t2_latency", 32'(lat), 32'd8);
    check_result("t2", 8'h00, 8'h11, 3'd0, 8'd0);
    rd = dut.bank_q ? dut.pm1_q : dut.pm0_q;
    check_eq("t2_pm0", 32'(rd[0]), 32'd0);
    check_eq("t2_pm4", 32'(rd[4]), 32'd2);

    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        in_valid = 1'b1; in_first = 1'b1; in_bm = 8'hFF;
      end else begin
        in_valid = 1'b0; in_first = 1'b0;
      end
      @(negedge clk);
      check_eq("t3_out_valid", 32'(out_valid), 32'd1);
      check_eq("t3_in_ready", 32'(in_ready), 32'd0);
      check_result("t3_hold", 8'h00, 8'h11, 3'd0, 8'd0);
    end
    in_valid = 1'b0; in_first = 1'b0;
    take();
    check_eq("t3_busy_after", 32'(busy), 32'd0);
    check_eq("t3_in_ready_after", 32'(in_ready), 32'd1);

    // All branch metrics equal: every surviving path ties, so selection stays 0.
    t4_pmv[0] = 8'h11; t4_pmv[1] = 8'h55; t4_pmv[2] = 8'hFF; t4_pmv[3] = 8'hFF;
    for (int s = 0; s < 4; s++) begin
      send(s == 0, 8'h55);
      wait_done(lat);
      check_result($sformatf("t4_sym%0d", s), 8'h00, t4_pmv[s], 3'd0, 8'd1);
      take();
    end

    for (int s = 0; s < 200; s++) begin
      first = (s == 0) || ($urandom_range(0, 15) == 0);
      bm    = 8'($urandom);
      model_step(first, bm, e_surv, e_valid, e_bs, e_bc);
      send(first, bm);
      wait_done(lat);
      check_eq("t5_latency", 32'(lat), 32'd8);
      check_result($sformatf("t5_sym%0d", s), e_surv, e_valid, e_bs, e_bc);
      rd  = dut.bank_q ? dut.pm1_q : dut.pm0_q;
      rdv = dut.bank_q ? dut.v1_q : dut.v0_q;
      mn = 255; mx = 0;
      for (int i = 0; i < 8; i++) begin
        check_eq($sformatf("t5_pm%0d", i), 32'(rd[i]), 32'(m_pm[i]));
        if (rdv[i]) begin
          if (int'(rd[i]) < mn) mn = int'(rd[i]);
          if (int'(rd[i]) > mx) mx = int'(rd[i]);
        end
      end
      check_eq("t5_min_zero", 32'(mn), 32'd0);
      check_eq("t5_max_le_18", 32'(mx <= 18), 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take();
    end

    // Reset mid-RUN at ns = 4, then an unflagged symbol must behave like a frame start.
    send(1'b0, 8'hE7);
    repeat (4) @(negedge clk);
    check_eq("t6_ns_at_reset", 32'(dut.ns_q), 32'd4);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check_result("t6_rst", 8'h00, 8'h01, 3'd0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 8'h94);
    wait_done(lat);
    check_eq("t6_latency", 32'(lat), 32'd8);
    check_result("t6", 8'h00, 8'h11, 3'd0, 8'd0);
    take();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
